ifetch_queue: RTL

Instruction-fetch front end of the pipelined MIPS core. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch FIFO that supplies the instruction and PC+4 to the Decode pipeline register. Decode stalls and branch/jump redirects from Decode are absorbed here, so a variable-latency instruction memory never stalls the datapath directly.

---
 rtl/ifq_pkg.sv | 13 +
 rtl/ifq_fifo.sv | 73 +++++++
 rtl/ifetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} ifq_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO of fetched words; clear wins over push and pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  ifq_entry_t  wdata,
    input  logic        pop,
    output ifq_entry_t  rdata,
    output logic        full,
    output logic        empty,
    output logic [PW:0] count
);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    ifq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_ONE;
            if (do_pop)  rptr_d = rptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC, single-outstanding imem request FSM and prefetch buffer feeding Decode.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pcplus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    ifq_state_t    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   redirect_tgt, addr_inc;
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    ifq_entry_t    wr_entry, head;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign addr_inc     = addr_q + 32'd4;
    assign pop          = !fifo_empty && !stall;
    assign wr_entry     = '{instr: imem_rdata, pcplus4: addr_inc};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end else if (!fifo_full) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_inc;
                    // This push fills the last free slot unless Decode drains one now.
                    if (!pop && (fifo_count == CNT_LAST)) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_inc;
                    end
                end
            end
            DRAIN: begin
                if (redirect) fetch_pc_d = redirect_tgt;
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? 32'h0 : head.instr;
    assign pcplus4     = fifo_empty ? 32'h0 : head.pcplus4;

endmodule
